// File: rtl/aes_pipe_perf_monitor_if.sv
// rtl/aes_pipe_perf_monitor_if.sv - control strobes and result bundle of the AES pipeline performance monitor
interface aes_pipe_perf_monitor_if #(
    parameter int CNT_W = 32,
    parameter int LAT_W = 16,
    parameter int DEPTH = 32
);
    localparam int IFW = $clog2(DEPTH) + 1;

    logic             start;
    logic             stop;
    logic             clear;
    logic             in_fire;
    logic             out_fire;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] blocks_in;
    logic [CNT_W-1:0] blocks_out;
    logic [IFW-1:0]   in_flight;
    logic             lat_valid;
    logic [LAT_W-1:0] lat_last;
    logic [LAT_W-1:0] lat_first;
    logic [LAT_W-1:0] lat_min;
    logic [LAT_W-1:0] lat_max;
    logic             err_overflow;
    logic             err_underflow;

    modport master (
        output start, stop, clear, in_fire, out_fire,
        input  state, cycles, blocks_in, blocks_out, in_flight, lat_valid,
               lat_last, lat_first, lat_min, lat_max, err_overflow, err_underflow
    );

    modport slave (
        input  start, stop, clear, in_fire, out_fire,
        output state, cycles, blocks_in, blocks_out, in_flight, lat_valid,
               lat_last, lat_first, lat_min, lat_max, err_overflow, err_underflow
    );
endinterface

// File: rtl/aes_pipe_perf_monitor.sv
// rtl/aes_pipe_perf_monitor.sv - per-block latency and throughput monitor for a pipelined AES core
module aes_pipe_perf_monitor #(
    parameter int CNT_W = 32,
    parameter int LAT_W = 16,
    parameter int DEPTH = 32
) (
    input logic                   clk,
    input logic                   reset,
    aes_pipe_perf_monitor_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int IFW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t           st, st_nxt;
    logic [CNT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [IFW-1:0]   count;
    logic [CNT_W-1:0] cycles, blocks_in, blocks_out;
    logic [LAT_W-1:0] lat_last, lat_first, lat_min, lat_max, lat;
    logic [CNT_W-1:0] diff;
    logic             lat_valid, err_overflow, err_underflow;
    logic             active, empty, full, pop, push_req, push, init;

    assign active   = (st == RUN) || (st == DRAIN);
    assign empty    = (count == '0);
    assign full     = (count == IFW'(DEPTH));
    assign pop      = active && bus.out_fire && !empty;
    assign push_req = (st == RUN) && bus.in_fire;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign init     = !reset || ((st == DONE) && bus.clear);

    assign diff = cycles - mem[rptr];
    assign lat  = (|diff[CNT_W-1:LAT_W]) ? '1 : diff[LAT_W-1:0];

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:  if (bus.start) st_nxt = RUN;
            RUN:   if (bus.stop)  st_nxt = DRAIN;
            DRAIN: if (empty)     st_nxt = DONE;
            DONE:  if (bus.clear) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            st            <= IDLE;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            cycles        <= '0;
            blocks_in     <= '0;
            blocks_out    <= '0;
            lat_valid     <= 1'b0;
            lat_last      <= '0;
            lat_first     <= '0;
            lat_min       <= '1;
            lat_max       <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            st        <= st_nxt;
            lat_valid <= pop;
            if (active && !(&cycles)) cycles <= cycles + CNT_W'(1);
            if (push) begin
                wptr      <= wptr + AW'(1);
                blocks_in <= blocks_in + CNT_W'(1);
            end
            if (pop) begin
                rptr       <= rptr + AW'(1);
                blocks_out <= blocks_out + CNT_W'(1);
                lat_last   <= lat;
                if (lat < lat_min)      lat_min   <= lat;
                if (lat > lat_max)      lat_max   <= lat;
                if (blocks_out == '0)   lat_first <= lat;
            end
            if (push && !pop)      count <= count + IFW'(1);
            else if (pop && !push) count <= count - IFW'(1);
            if (push_req && !push)             err_overflow  <= 1'b1;
            if (active && bus.out_fire && empty) err_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= cycles;
    end

    assign bus.state         = st;
    assign bus.cycles        = cycles;
    assign bus.blocks_in     = blocks_in;
    assign bus.blocks_out    = blocks_out;
    assign bus.in_flight     = count;
    assign bus.lat_valid     = lat_valid;
    assign bus.lat_last      = lat_last;
    assign bus.lat_first     = lat_first;
    assign bus.lat_min       = lat_min;
    assign bus.lat_max       = lat_max;
    assign bus.err_overflow  = err_overflow;
    assign bus.err_underflow = err_underflow;
endmodule

// File: tb/tb_aes_pipe_perf_monitor.sv
// tb/tb_aes_pipe_perf_monitor.sv - bench for the AES pipeline monitor, two configurations against a queue model
module tb_aes_pipe_perf_monitor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0, in_fire = 1'b0, out_fire = 1'b0;

    always #5 clk = ~clk;

    aes_pipe_perf_monitor_if #(.CNT_W(32), .LAT_W(16), .DEPTH(32)) ia ();
    aes_pipe_perf_monitor_if #(.CNT_W(32), .LAT_W(4),  .DEPTH(4))  ib ();

    assign ia.start = start;  assign ia.stop = stop;  assign ia.clear = clear;
    assign ia.in_fire = in_fire;  assign ia.out_fire = out_fire;
    assign ib.start = start;  assign ib.stop = stop;  assign ib.clear = clear;
    assign ib.in_fire = in_fire;  assign ib.out_fire = out_fire;

    aes_pipe_perf_monitor #(.CNT_W(32), .LAT_W(16), .DEPTH(32)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    aes_pipe_perf_monitor #(.CNT_W(32), .LAT_W(4),  .DEPTH(4))  dut_b (.clk(clk), .reset(reset), .bus(ib));

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    // Model: one timestamp queue per configuration, results derived from queue arithmetic.
    int     m_depth [2] = '{32, 4};
    longint m_latmax[2] = '{65535, 15};
    int     m_st [2];
    longint m_cyc[2], m_bin[2], m_bout[2], m_last[2], m_first[2], m_min[2], m_max[2];
    bit     m_lv[2], m_eo[2], m_eu[2];
    longint mq[2][$];

    task automatic model_init(int d);
        m_st[d] = 0;  m_cyc[d] = 0;  m_bin[d] = 0;  m_bout[d] = 0;
        m_last[d] = 0;  m_first[d] = 0;  m_min[d] = m_latmax[d];  m_max[d] = 0;
        m_lv[d] = 0;  m_eo[d] = 0;  m_eu[d] = 0;
        mq[d].delete();
    endtask

    task automatic model_step(int d);
        bit act, pop, preq, push;
        int sz;
        longint lat;
        if (!reset) begin
            model_init(d);
            return;
        end
        if (m_st[d] == 3 && clear) begin
            model_init(d);
            return;
        end
        act  = (m_st[d] == 1) || (m_st[d] == 2);
        sz   = mq[d].size();
        pop  = act && out_fire && (sz > 0);
        preq = (m_st[d] == 1) && in_fire;
        push = preq && ((sz < m_depth[d]) || pop);
        m_lv[d] = pop;
        if (act && out_fire && sz == 0) m_eu[d] = 1;
        if (preq && !push) m_eo[d] = 1;
        if (pop) begin
            lat = m_cyc[d] - mq[d].pop_front();
            if (lat > m_latmax[d]) lat = m_latmax[d];
            m_last[d] = lat;
            if (m_bout[d] == 0) m_first[d] = lat;
            if (lat < m_min[d]) m_min[d] = lat;
            if (lat > m_max[d]) m_max[d] = lat;
            m_bout[d]++;
        end
        if (push) begin
            mq[d].push_back(m_cyc[d]);
            m_bin[d]++;
        end
        if (act && m_cyc[d] < 64'hFFFF_FFFF) m_cyc[d]++;
        case (m_st[d])
            0: if (start) m_st[d] = 1;
            1: if (stop)  m_st[d] = 2;
            2: if (sz == 0) m_st[d] = 3;
            default: ;
        endcase
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic check_dut(int d, logic [1:0] st, logic [31:0] cy, logic [31:0] bi, logic [31:0] bo,
                             logic [5:0] inf, logic lv, logic [15:0] ll, logic [15:0] lf,
                             logic [15:0] lmn, logic [15:0] lmx, logic eo, logic eu);
        chk($sformatf("d%0d state", d),         64'(st),  64'(m_st[d]));
        chk($sformatf("d%0d cycles", d),        64'(cy),  64'(m_cyc[d]));
        chk($sformatf("d%0d blocks_in", d),     64'(bi),  64'(m_bin[d]));
        chk($sformatf("d%0d blocks_out", d),    64'(bo),  64'(m_bout[d]));
        chk($sformatf("d%0d in_flight", d),     64'(inf), 64'(mq[d].size()));
        chk($sformatf("d%0d lat_valid", d),     64'(lv),  64'(m_lv[d]));
        chk($sformatf("d%0d lat_last", d),      64'(ll),  64'(m_last[d]));
        chk($sformatf("d%0d lat_first", d),     64'(lf),  64'(m_first[d]));
        chk($sformatf("d%0d lat_min", d),       64'(lmn), 64'(m_min[d]));
        chk($sformatf("d%0d lat_max", d),       64'(lmx), 64'(m_max[d]));
        chk($sformatf("d%0d err_overflow", d),  64'(eo),  64'(m_eo[d]));
        chk($sformatf("d%0d err_underflow", d), 64'(eu),  64'(m_eu[d]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc_no++;
        #1;
        check_dut(0, ia.state, ia.cycles, ia.blocks_in, ia.blocks_out, 6'(ia.in_flight), ia.lat_valid,
                  ia.lat_last, ia.lat_first, ia.lat_min, ia.lat_max, ia.err_overflow, ia.err_underflow);
        check_dut(1, ib.state, ib.cycles, ib.blocks_in, ib.blocks_out, 6'(ib.in_flight), ib.lat_valid,
                  16'(ib.lat_last), 16'(ib.lat_first), 16'(ib.lat_min), 16'(ib.lat_max),
                  ib.err_overflow, ib.err_underflow);
    endtask

    task automatic do_reset();
        reset = 1'b0;  start = 0;  stop = 0;  clear = 0;  in_fire = 0;  out_fire = 0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int pulses, maxif, nblk, nseen, t, prev_out, lo, tend;
        int lats[16];
        int tin[16];
        bit ins[256];
        bit outs[256];

        // Reset state
        tick();
        chk("rst state_a", 64'(ia.state), 64'd0);
        chk("rst lat_min_a", 64'(ia.lat_min), 64'hFFFF);
        chk("rst lat_min_b", 64'(ib.lat_min), 64'hF);
        reset = 1'b1;
        tick();

        // 11-cycle pipeline, 15 back-to-back blocks
        pulse_start();
        pulses = 0;  maxif = 0;
        for (int k = 0; k < 30; k++) begin
            in_fire  = (k < 15);
            out_fire = (k >= 11) && (k < 26);
            tick();
            if (ia.lat_valid) begin
                pulses++;
                chk("pipe11 lat", 64'(ia.lat_last), 64'd11);
            end
            if (int'(ia.in_flight) > maxif) maxif = int'(ia.in_flight);
        end
        in_fire = 0;  out_fire = 0;
        stop = 1'b1;  tick();  stop = 1'b0;
        tick();  tick();
        chk("pipe11 pulses", 64'(pulses), 64'd15);
        chk("pipe11 max_in_flight", 64'(maxif), 64'd11);
        chk("pipe11 blocks_in", 64'(ia.blocks_in), 64'd15);
        chk("pipe11 blocks_out", 64'(ia.blocks_out), 64'd15);
        chk("pipe11 done", 64'(ia.state), 64'd3);
        clear = 1'b1;  tick();  clear = 1'b0;
        chk("clear idle", 64'(ia.state), 64'd0);

        // Random stall pattern, latencies 3..9
        for (int i = 0; i < 256; i++) begin ins[i] = 0; outs[i] = 0; end
        nblk = 12;  t = 0;  prev_out = -1;
        for (int i = 0; i < nblk; i++) begin
            if (i > 0) t = t + $urandom_range(1, 3);
            tin[i] = t;
            if (i == 0)      lats[i] = 3;
            else if (i == 1) lats[i] = 9;
            else begin
                lo = prev_out - t + 1;
                if (lo < 3) lo = 3;
                lats[i] = $urandom_range(lo, 9);
            end
            prev_out = t + lats[i];
            ins[t] = 1;
            outs[prev_out] = 1;
        end
        tend = prev_out + 2;
        pulse_start();
        nseen = 0;
        for (int k = 0; k < tend; k++) begin
            in_fire = ins[k];  out_fire = outs[k];
            tick();
            if (ia.lat_valid) begin
                chk("rand lat_last", 64'(ia.lat_last), 64'(lats[nseen]));
                nseen++;
            end
        end
        in_fire = 0;  out_fire = 0;
        chk("rand pulses", 64'(nseen), 64'(nblk));
        chk("rand lat_min", 64'(ia.lat_min), 64'd3);
        chk("rand lat_max", 64'(ia.lat_max), 64'd9);
        chk("rand lat_first", 64'(ia.lat_first), 64'(lats[0]));
        do_reset();

        // DEPTH=4 with the core stalled
        pulse_start();
        in_fire = 1;
        repeat (4) tick();
        chk("full in_flight", 64'(ib.in_flight), 64'd4);
        out_fire = 1;  tick();  out_fire = 0;
        chk("full pushpop no err", 64'(ib.err_overflow), 64'd0);
        chk("full pushpop in_flight", 64'(ib.in_flight), 64'd4);
        chk("full pushpop blocks_in", 64'(ib.blocks_in), 64'd5);
        tick();
        in_fire = 0;
        chk("overflow flag", 64'(ib.err_overflow), 64'd1);
        chk("overflow blocks_in", 64'(ib.blocks_in), 64'd5);
        do_reset();

        // Underflow with a same-cycle push
        pulse_start();
        in_fire = 1;  out_fire = 1;  tick();  in_fire = 0;  out_fire = 0;
        chk("underflow flag", 64'(ia.err_underflow), 64'd1);
        chk("underflow in_flight", 64'(ia.in_flight), 64'd1);
        chk("underflow lat_valid", 64'(ia.lat_valid), 64'd0);
        do_reset();

        // 20-cycle pipeline saturates a 4-bit latency
        pulse_start();
        in_fire = 1;  tick();  in_fire = 0;
        repeat (19) tick();
        out_fire = 1;  tick();  out_fire = 0;
        chk("sat lat_last_b", 64'(ib.lat_last), 64'd15);
        chk("sat lat_last_a", 64'(ia.lat_last), 64'd20);
        do_reset();

        // Stop with 3 in flight, in_fire during DRAIN
        pulse_start();
        in_fire = 1;  repeat (3) tick();  in_fire = 0;
        stop = 1;  tick();  stop = 0;
        in_fire = 1;  tick();  in_fire = 0;
        out_fire = 1;  repeat (3) tick();  out_fire = 0;
        chk("drain still draining", 64'(ia.state), 64'd2);
        tick();
        chk("drain done", 64'(ia.state), 64'd3);
        chk("drain blocks_in", 64'(ia.blocks_in), 64'd3);
        clear = 1;  tick();  clear = 0;
        chk("drain clear idle", 64'(ia.state), 64'd0);
        chk("drain clear lat_min", 64'(ia.lat_min), 64'hFFFF);

        // Random bursts then reset mid-run
        pulse_start();
        repeat (40) begin
            in_fire  = $urandom_range(0, 1);
            out_fire = $urandom_range(0, 1);
            tick();
        end
        in_fire = 0;  out_fire = 0;
        reset = 0;  tick();
        chk("midreset state", 64'(ia.state), 64'd0);
        chk("midreset cycles", 64'(ia.cycles), 64'd0);
        chk("midreset lat_min_b", 64'(ib.lat_min), 64'hF);
        reset = 1;  tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
